// File: rtl/multi_channel_interval_timer.sv
// Avalon-MM interval timer with NUM_CH independent down-counting channels.
// Each channel has a prescaler, one-shot/continuous modes, snapshot capture and a maskable IRQ.
module multi_channel_interval_timer #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          PRE_W        = 8,
  parameter int unsigned PERIOD_RESET = 49999,
  parameter int          ADDR_W       = 3 + ((NUM_CH > 1) ? $clog2(NUM_CH) : 0)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RESET);

  logic [CNT_W-1:0] count_q  [NUM_CH];
  logic [CNT_W-1:0] period_q [NUM_CH];
  logic [CNT_W-1:0] snap_q   [NUM_CH];
  logic [PRE_W-1:0] pre_q    [NUM_CH];
  logic [PRE_W-1:0] div_q    [NUM_CH];

  logic [NUM_CH-1:0] ito_q;
  logic [NUM_CH-1:0] cont_q;
  logic [NUM_CH-1:0] run_q;
  logic [NUM_CH-1:0] to_q;
  logic [NUM_CH-1:0] zero_d_q;
  logic [NUM_CH-1:0] reload_q;
  logic [NUM_CH-1:0] tick_q;

  logic [31:0] ch_sel;
  logic [2:0]  reg_sel;
  logic        wr_en;

  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] wr_stat;
  logic [NUM_CH-1:0] wr_ctl;
  logic [NUM_CH-1:0] wr_perl;
  logic [NUM_CH-1:0] wr_perh;
  logic [NUM_CH-1:0] wr_snap;
  logic [NUM_CH-1:0] wr_pre;
  logic [NUM_CH-1:0] start;
  logic [NUM_CH-1:0] stop;
  logic [NUM_CH-1:0] cnt_zero;
  logic [NUM_CH-1:0] tick_en;
  logic [NUM_CH-1:0] evt;
  logic [NUM_CH-1:0] oneshot_end;

  logic [CNT_W-1:0] per_lo_nx [NUM_CH];
  logic [CNT_W-1:0] per_hi_nx [NUM_CH];
  logic [15:0]      rd_mux;

  assign ch_sel  = 32'(address) >> 3;
  assign reg_sel = address[2:0];
  assign wr_en   = chipselect && !write_n;

  // Channel indices with no matching channel select nothing: writes drop, reads mux to 0.
  always_comb begin
    sel         = '0;
    wr_stat     = '0;
    wr_ctl      = '0;
    wr_perl     = '0;
    wr_perh     = '0;
    wr_snap     = '0;
    wr_pre      = '0;
    start       = '0;
    stop        = '0;
    cnt_zero    = '0;
    tick_en     = '0;
    evt         = '0;
    oneshot_end = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c]         = (ch_sel == 32'(c));
      wr_stat[c]     = wr_en && sel[c] && (reg_sel == 3'd0);
      wr_ctl[c]      = wr_en && sel[c] && (reg_sel == 3'd1);
      wr_perl[c]     = wr_en && sel[c] && (reg_sel == 3'd2);
      wr_perh[c]     = wr_en && sel[c] && (reg_sel == 3'd3);
      wr_snap[c]     = wr_en && sel[c] && ((reg_sel == 3'd4) || (reg_sel == 3'd5));
      wr_pre[c]      = wr_en && sel[c] && (reg_sel == 3'd6);
      start[c]       = wr_ctl[c] && writedata[2];
      stop[c]        = wr_ctl[c] && writedata[3];
      cnt_zero[c]    = (count_q[c] == '0);
      tick_en[c]     = run_q[c] && (div_q[c] == pre_q[c]);
      evt[c]         = cnt_zero[c] && !zero_d_q[c];
      oneshot_end[c] = run_q[c] && !cont_q[c] && cnt_zero[c];
    end
  end

  // Half-word period updates; bits above CNT_W fall off in the truncating cast.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      per_lo_nx[c]       = period_q[c];
      per_lo_nx[c][15:0] = writedata;
      per_hi_nx[c]       = CNT_W'({writedata, period_q[c][15:0]});
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count_q[c]  <= PERIOD_INIT;
        period_q[c] <= PERIOD_INIT;
        snap_q[c]   <= '0;
        pre_q[c]    <= '0;
        div_q[c]    <= '0;
      end
      ito_q    <= '0;
      cont_q   <= '0;
      run_q    <= '0;
      to_q     <= '0;
      zero_d_q <= '1;
      reload_q <= '0;
      tick_q   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        zero_d_q[c] <= cnt_zero[c];
        tick_q[c]   <= evt[c];
        reload_q[c] <= wr_perl[c] || wr_perh[c];

        // A timeout on the same edge as a status write must not be lost.
        if (evt[c]) begin
          to_q[c] <= 1'b1;
        end else if (wr_stat[c]) begin
          to_q[c] <= 1'b0;
        end

        if (wr_ctl[c]) begin
          ito_q[c]  <= writedata[0];
          cont_q[c] <= writedata[1];
        end

        if (wr_pre[c]) begin
          pre_q[c] <= writedata[PRE_W-1:0];
        end

        if (wr_perl[c]) begin
          period_q[c] <= per_lo_nx[c];
        end else if (wr_perh[c]) begin
          period_q[c] <= per_hi_nx[c];
        end

        if (wr_snap[c]) begin
          snap_q[c] <= count_q[c];
        end

        if (start[c]) begin
          run_q[c] <= 1'b1;
        end else if (stop[c] || reload_q[c] || oneshot_end[c]) begin
          run_q[c] <= 1'b0;
        end

        if (!run_q[c] || wr_pre[c] || reload_q[c] || (div_q[c] == pre_q[c])) begin
          div_q[c] <= '0;
        end else begin
          div_q[c] <= div_q[c] + PRE_W'(1);
        end

        // A finished one-shot parks at zero; only continuous mode reloads from zero.
        if (reload_q[c]) begin
          count_q[c] <= period_q[c];
        end else if (tick_en[c]) begin
          if (!cnt_zero[c]) begin
            count_q[c] <= count_q[c] - CNT_W'(1);
          end else if (cont_q[c]) begin
            count_q[c] <= period_q[c];
          end
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel[c]) begin
        case (reg_sel)
          3'd0:    rd_mux = {14'd0, run_q[c], to_q[c]};
          3'd1:    rd_mux = {14'd0, cont_q[c], ito_q[c]};
          3'd2:    rd_mux = 16'(32'(period_q[c]));
          3'd3:    rd_mux = 16'(32'(period_q[c]) >> 16);
          3'd4:    rd_mux = 16'(32'(snap_q[c]));
          3'd5:    rd_mux = 16'(32'(snap_q[c]) >> 16);
          3'd6:    rd_mux = 16'(pre_q[c]);
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq_vec = to_q & ito_q;
  assign irq     = |irq_vec;
  assign tick    = tick_q;

endmodule
